// File: rtl/isp_restart_pkg.sv
// Shared state encoding for the post-ISP restart trigger.
package isp_restart_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_QUALIFY = 3'd1,
        ST_DELAY   = 3'd2,
        ST_REQUEST = 3'd3,
        ST_DONE    = 3'd4,
        ST_ERROR   = 3'd5
    } state_e;

endpackage

// File: rtl/isp_sync_ff.sv
// Reset-to-0 multi-flop synchronizer for a single asynchronous level.
module isp_sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift the asynchronous level through the synchronizer chain.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/isp_restart_trigger.sv
// Qualifies the MSS ISP-done flag, waits for UART drain, then requests a
// device restart over req/ack with timeout, bounded retries and sticky error.
module isp_restart_trigger
    import isp_restart_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int QUAL_CYCLES  = 16,
    parameter int DELAY_CYCLES = 50000,
    parameter int ACK_TIMEOUT  = 1000,
    parameter int MAX_RETRIES  = 3,
    localparam int RC_W = ($clog2(MAX_RETRIES + 1) < 1) ? 1 : $clog2(MAX_RETRIES + 1)
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               ISP_DONE_ASYNC,
    input  logic               ARM,
    input  logic               ABORT,
    input  logic               RESTART_ACK,
    output logic               RESTART_REQ,
    output logic               BUSY,
    output logic               ERR,
    output logic [STATE_W-1:0] STATE,
    output logic [RC_W-1:0]    RETRY_CNT
);

    localparam int CNT_MAX_QD = (QUAL_CYCLES > DELAY_CYCLES) ? QUAL_CYCLES : DELAY_CYCLES;
    localparam int CNT_MAX    = (CNT_MAX_QD > ACK_TIMEOUT) ? CNT_MAX_QD : ACK_TIMEOUT;
    localparam int CNT_W      = ($clog2(CNT_MAX) < 1) ? 1 : $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] QUAL_LAST  = CNT_W'(QUAL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACK_LAST   = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [RC_W-1:0]  RC_MAX     = RC_W'(MAX_RETRIES);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RC_W-1:0]  retry_q, retry_d;
    logic             done_s;

    isp_sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_done_sync (
        .clk_i (CLK),
        .rst_i (RESET),
        .d_i   (ISP_DONE_ASYNC),
        .q_o   (done_s)
    );

    // State, shared counter and retry count registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
        end
    end

    // Next-state, counter and retry logic; ABORT overrides everything.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        if (ABORT) begin
            state_d = ST_IDLE;
            retry_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ARM && done_s) begin
                        state_d = ST_QUALIFY;
                        retry_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_QUALIFY: begin
                    if (!done_s) begin
                        state_d = ST_IDLE;
                    end else if (cnt_q == QUAL_LAST) begin
                        state_d = ST_DELAY;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_DELAY: begin
                    if (cnt_q == DELAY_LAST) begin
                        state_d = ST_REQUEST;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_REQUEST: begin
                    // Ack is checked first so it wins over a coincident timeout.
                    if (RESTART_ACK) begin
                        state_d = ST_DONE;
                    end else if (cnt_q == ACK_LAST) begin
                        if (retry_q < RC_MAX) begin
                            retry_d = retry_q + RC_W'(1);
                            state_d = ST_DELAY;
                        end else begin
                            state_d = ST_ERROR;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (!RESTART_ACK && !done_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                ST_ERROR: begin
                    state_d = ST_ERROR;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        if (ABORT || (state_d != state_q)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_d;
        end
    end

    assign RESTART_REQ = (state_q == ST_REQUEST);
    assign BUSY        = (state_q != ST_IDLE) && (state_q != ST_ERROR);
    assign ERR         = (state_q == ST_ERROR);
    assign STATE       = state_q;
    assign RETRY_CNT   = retry_q;

endmodule

// File: tb/tb_isp_restart_trigger.sv
// Directed scoreboard bench: expectations are queued per clock cycle when
// stimulus is applied and compared by a monitor thread on the falling edge.
module tb_isp_restart_trigger;

    localparam int SYNC = 2;
    localparam int QUAL = 4;
    localparam int DLY  = 8;
    localparam int TMO  = 5;
    localparam int MAXR = 2;

    logic       CLK;
    logic       RESET;
    logic       ISP_DONE_ASYNC;
    logic       ARM;
    logic       ABORT;
    logic       RESTART_ACK;
    logic       RESTART_REQ;
    logic       BUSY;
    logic       ERR;
    logic [2:0] STATE;
    logic [1:0] RETRY_CNT;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int         cyc;
        string      tag;
        logic [2:0] st;
        logic [1:0] rc;
    } exp_t;

    exp_t sb_q[$];

    isp_restart_trigger #(
        .SYNC_STAGES  (SYNC),
        .QUAL_CYCLES  (QUAL),
        .DELAY_CYCLES (DLY),
        .ACK_TIMEOUT  (TMO),
        .MAX_RETRIES  (MAXR)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .ISP_DONE_ASYNC (ISP_DONE_ASYNC),
        .ARM            (ARM),
        .ABORT          (ABORT),
        .RESTART_ACK    (RESTART_ACK),
        .RESTART_REQ    (RESTART_REQ),
        .BUSY           (BUSY),
        .ERR            (ERR),
        .STATE          (STATE),
        .RETRY_CNT      (RETRY_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic push_exp(input int off, input string tag, input logic [2:0] st, input logic [1:0] rc);
        exp_t e;
        e.cyc = cyc + off;
        e.tag = tag;
        e.st  = st;
        e.rc  = rc;
        sb_q.push_back(e);
    endtask

    task automatic exp_range(input int a, input int b, input string tag, input logic [2:0] st, input logic [1:0] rc);
        for (int o = a; o <= b; o++) push_exp(o, tag, st, rc);
    endtask

    // REQ, BUSY and ERR expectations follow from the expected state.
    task automatic check_entry(input exp_t e);
        logic [7:0] obs;
        logic [7:0] expv;
        obs  = {RESTART_REQ, BUSY, ERR, STATE, RETRY_CNT};
        expv = {(e.st == 3'd3), (e.st != 3'd0 && e.st != 3'd5), (e.st == 3'd5), e.st, e.rc};
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s cyc=%0d req/busy/err/state/rc observed=%b expected=%b", e.tag, cyc, obs, expv);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        exp_t now_e;
        RESET          = 1'b1;
        ISP_DONE_ASYNC = 1'b0;
        ARM            = 1'b0;
        ABORT          = 1'b0;
        RESTART_ACK    = 1'b0;

        fork
            forever begin
                @(negedge CLK);
                for (int i = sb_q.size() - 1; i >= 0; i--) begin
                    if (sb_q[i].cyc <= cyc) begin
                        check_entry(sb_q[i]);
                        sb_q.delete(i);
                    end
                end
            end
        join_none

        // Reset state
        wait_cyc(1);
        exp_range(1, 2, "reset_hold", 3'd0, 2'd0);
        wait_cyc(2);
        RESET = 1'b0;
        exp_range(1, 3, "reset_idle", 3'd0, 2'd0);
        wait_cyc(4);

        // 1. Nominal: REQ 13 cycles after done_s, ack after 3 REQ cycles
        ARM = 1'b1;
        ISP_DONE_ASYNC = 1'b1;
        exp_range(1, 2, "s1_idle", 3'd0, 2'd0);
        exp_range(3, 6, "s1_qual", 3'd1, 2'd0);
        exp_range(7, 14, "s1_delay", 3'd2, 2'd0);
        exp_range(15, 17, "s1_req", 3'd3, 2'd0);
        wait_cyc(17);
        RESTART_ACK = 1'b1;
        push_exp(1, "s1_done", 3'd4, 2'd0);
        wait_cyc(1);
        RESTART_ACK = 1'b0;
        ISP_DONE_ASYNC = 1'b0;
        exp_range(1, 2, "s1_done_hold", 3'd4, 2'd0);
        exp_range(3, 6, "s1_back_idle", 3'd0, 2'd0);
        wait_cyc(6);

        // 2. Glitch: 3-cycle pulse never completes qualification
        ISP_DONE_ASYNC = 1'b1;
        exp_range(1, 2, "s2_idle", 3'd0, 2'd0);
        exp_range(3, 5, "s2_qual", 3'd1, 2'd0);
        exp_range(6, 20, "s2_drop", 3'd0, 2'd0);
        wait_cyc(3);
        ISP_DONE_ASYNC = 1'b0;
        wait_cyc(18);

        // 3. No ack: three attempts then sticky error, cleared by ABORT
        ISP_DONE_ASYNC = 1'b1;
        exp_range(1, 2, "s3_idle", 3'd0, 2'd0);
        exp_range(3, 6, "s3_qual", 3'd1, 2'd0);
        exp_range(7, 14, "s3_delay0", 3'd2, 2'd0);
        exp_range(15, 19, "s3_req0", 3'd3, 2'd0);
        exp_range(20, 27, "s3_delay1", 3'd2, 2'd1);
        exp_range(28, 32, "s3_req1", 3'd3, 2'd1);
        exp_range(33, 40, "s3_delay2", 3'd2, 2'd2);
        exp_range(41, 45, "s3_req2", 3'd3, 2'd2);
        exp_range(46, 47, "s3_error", 3'd5, 2'd2);
        wait_cyc(47);
        ISP_DONE_ASYNC = 1'b0;
        ARM = 1'b0;
        exp_range(1, 2, "s3_error_sticky", 3'd5, 2'd2);
        wait_cyc(2);
        ABORT = 1'b1;
        exp_range(1, 5, "s3_abort_idle", 3'd0, 2'd0);
        wait_cyc(1);
        ABORT = 1'b0;
        wait_cyc(5);

        // 4. ABORT in DELAY at cnt=3, then full re-qualification
        ARM = 1'b1;
        ISP_DONE_ASYNC = 1'b1;
        exp_range(1, 2, "s4_idle", 3'd0, 2'd0);
        exp_range(3, 6, "s4_qual", 3'd1, 2'd0);
        exp_range(7, 10, "s4_delay", 3'd2, 2'd0);
        wait_cyc(10);
        ABORT = 1'b1;
        push_exp(1, "s4_abort", 3'd0, 2'd0);
        wait_cyc(1);
        ABORT = 1'b0;
        exp_range(1, 4, "s4_requal", 3'd1, 2'd0);
        exp_range(5, 12, "s4_redelay", 3'd2, 2'd0);
        push_exp(13, "s4_req", 3'd3, 2'd0);
        wait_cyc(13);
        RESTART_ACK = 1'b1;
        push_exp(1, "s4_done", 3'd4, 2'd0);
        wait_cyc(1);
        RESTART_ACK = 1'b0;
        ISP_DONE_ASYNC = 1'b0;
        exp_range(1, 2, "s4_done_hold", 3'd4, 2'd0);
        exp_range(3, 5, "s4_back_idle", 3'd0, 2'd0);
        wait_cyc(5);

        // 5. Ack on the final timeout cycle wins over the retry
        ISP_DONE_ASYNC = 1'b1;
        exp_range(1, 2, "s5_idle", 3'd0, 2'd0);
        exp_range(3, 6, "s5_qual", 3'd1, 2'd0);
        exp_range(7, 14, "s5_delay", 3'd2, 2'd0);
        exp_range(15, 19, "s5_req", 3'd3, 2'd0);
        wait_cyc(19);
        RESTART_ACK = 1'b1;
        push_exp(1, "s5_ack_wins", 3'd4, 2'd0);
        wait_cyc(1);
        RESTART_ACK = 1'b0;
        ISP_DONE_ASYNC = 1'b0;
        exp_range(1, 2, "s5_done_hold", 3'd4, 2'd0);
        exp_range(3, 10, "s5_no_second_req", 3'd0, 2'd0);
        wait_cyc(10);

        // 6. Asynchronous reset between edges during REQUEST
        ISP_DONE_ASYNC = 1'b1;
        exp_range(1, 2, "s6_idle", 3'd0, 2'd0);
        exp_range(3, 6, "s6_qual", 3'd1, 2'd0);
        exp_range(7, 14, "s6_delay", 3'd2, 2'd0);
        exp_range(15, 17, "s6_req", 3'd3, 2'd0);
        wait_cyc(17);
        #2;
        RESET = 1'b1;
        #1;
        now_e.cyc = cyc;
        now_e.tag = "s6_async_reset";
        now_e.st  = 3'd0;
        now_e.rc  = 2'd0;
        check_entry(now_e);
        wait_cyc(1);
        RESET = 1'b0;
        exp_range(1, 2, "s6_post_idle", 3'd0, 2'd0);
        exp_range(3, 6, "s6_post_qual", 3'd1, 2'd0);
        exp_range(7, 14, "s6_post_delay", 3'd2, 2'd0);
        push_exp(15, "s6_post_req", 3'd3, 2'd0);
        wait_cyc(15);
        RESTART_ACK = 1'b1;
        push_exp(1, "s6_done", 3'd4, 2'd0);
        wait_cyc(1);
        RESTART_ACK = 1'b0;
        ISP_DONE_ASYNC = 1'b0;
        ARM = 1'b0;
        exp_range(1, 2, "s6_done_hold", 3'd4, 2'd0);
        exp_range(3, 5, "s6_back_idle", 3'd0, 2'd0);
        wait_cyc(5);

        for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge CLK);
        vectors++;
        assert (sb_q.size() == 0) else begin
            miscompares++;
            $error("FAIL sb_drain pending observed=%0d expected=0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
